// File: rtl/des_keysched_stream.sv
// DES key-schedule streamer: turns a PC-1 permuted C||D key into 16 PC-2 round keys,
// one per accepted valid/ready beat, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_keysched_stream #(
    parameter int ROUND_W   = 4,
    parameter int CD_OUT_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               decrypt,
    input  logic [55:0]        key_cd,
    output logic [47:0]        rk,
    output logic [ROUND_W-1:0] rk_round,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic               busy,
    output logic               done,
    output logic [55:0]        cd_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 1-based DES bit positions of C||D feeding each round-key bit, MSB (DES bit 1) first
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t             state;
    state_t             state_next;
    logic [55:0]        cd;
    logic [55:0]        cd_next;
    logic [ROUND_W-1:0] count;
    logic [ROUND_W-1:0] count_next;
    logic               mode;
    logic               mode_next;
    logic [4:0]         count_inc;
    logic [4:0]         shift_idx;
    logic               last_beat;

    // Shift table entries 1, 2, 9 and 16 rotate by one; every other round rotates by two.
    function automatic logic is_double(input logic [4:0] n);
        return !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] h, input logic two);
        return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] h, input logic two);
        return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

    function automatic logic [55:0] rot_cd(input logic [55:0] v, input logic left, input logic two);
        logic [27:0] c;
        logic [27:0] d;
        if (left) begin
            c = rotl28(v[55:28], two);
            d = rotl28(v[27:0], two);
        end else begin
            c = rotr28(v[55:28], two);
            d = rotr28(v[27:0], two);
        end
        return {c, d};
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] v);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[47-j] = v[56-PC2_TAB[j]];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cd    <= '0;
            count <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_next;
            cd    <= cd_next;
            count <= count_next;
            mode  <= mode_next;
        end
    end

    assign count_inc = 5'(count) + 5'd1;
    assign last_beat = (count == ROUND_W'(15));
    // Encrypt looks ahead to shift[n+1]; decrypt undoes shift[17-n] walking backwards.
    assign shift_idx = mode ? (5'd17 - count_inc) : (count_inc + 5'd1);

    always_comb begin
        state_next = state;
        cd_next    = cd;
        count_next = count;
        mode_next  = mode;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_next  = decrypt;
                    count_next = '0;
                    // CD16 equals CD0, so decrypt starts from the unrotated key.
                    cd_next    = decrypt ? key_cd : rot_cd(key_cd, 1'b1, 1'b0);
                    state_next = RUN;
                end
            end
            RUN: begin
                if (rk_ready) begin
                    if (last_beat) begin
                        state_next = DONE;
                    end else begin
                        count_next = ROUND_W'(count_inc);
                        cd_next    = rot_cd(cd, !mode, is_double(shift_idx));
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rk_valid = (state == RUN);
    assign rk       = rk_valid ? pc2(cd) : '0;
    assign rk_round = rk_valid ? count : '0;
    assign busy     = (state == RUN) || (state == DONE);
    assign done     = (state == DONE);
    assign cd_out   = (CD_OUT_EN != 0) ? cd : '0;

endmodule

// File: tb/tb_des_keysched_stream.sv
// Directed bench for des_keysched_stream: table of schedules checked beat by beat,
// plus hand-written start-while-busy and mid-schedule reset sequences.
module tb_des_keysched_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [55:0] key_cd;
    logic        rk_ready;
    logic [47:0] rk;
    logic [3:0]  rk_round;
    logic        rk_valid;
    logic        busy;
    logic        done;
    logic [55:0] cd_out;
    logic [47:0] rk_b;
    logic [3:0]  rk_round_b;
    logic        rk_valid_b;
    logic        busy_b;
    logic        done_b;
    logic [55:0] cd_out_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    des_keysched_stream #(.ROUND_W(4), .CD_OUT_EN(1)) dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_cd(key_cd),
        .rk(rk), .rk_round(rk_round), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .busy(busy), .done(done), .cd_out(cd_out)
    );

    des_keysched_stream #(.ROUND_W(4), .CD_OUT_EN(0)) dut_nocd (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_cd(key_cd),
        .rk(rk_b), .rk_round(rk_round_b), .rk_valid(rk_valid_b), .rk_ready(rk_ready),
        .busy(busy_b), .done(done_b), .cd_out(cd_out_b)
    );

    localparam logic [55:0] KEY_CLASSIC = 56'hF0CCAAF556678F;
    localparam logic [55:0] CD1_CLASSIC = 56'hE19955FAACCF1E;

    // Round keys K1..K16 of the classic 133457799BBCDFF1 example
    logic [47:0] ks [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct {
        logic        dec;
        logic        rnd;
        logic [55:0] key;
        int          kind;
        logic [55:0] first_cd;
        logic [55:0] last_cd;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] exp_rk(input vec_t v, input int b);
        if (v.kind == 0) return v.dec ? ks[15-b] : ks[b];
        if (v.kind == 1) return '1;
        return '0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rk"}, 64'(rk), 64'd0);
        check({tag, "_round"}, 64'(rk_round), 64'd0);
        check({tag, "_valid"}, 64'(rk_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_cd"}, 64'(cd_out), 64'd0);
    endtask

    task automatic run_sched(input vec_t v, input int id, input int start_beat, input int rst_beat);
        int          beat = 0;
        int          cyc = 0;
        bit          injected = 0;
        logic        r;
        logic [47:0] prk;
        logic [3:0]  prr;
        string       t;
        t = $sformatf("v%0d", id);
        @(posedge clk); #1;
        start = 1'b1; decrypt = v.dec; key_cd = v.key;
        @(posedge clk); #1;
        start = 1'b0; decrypt = ~v.dec; key_cd = ~v.key;
        check({t, "_first_valid"}, 64'(rk_valid), 64'd1);
        while (beat < 16 && cyc < 400) begin
            t = $sformatf("v%0d_b%0d", id, beat);
            check({t, "_valid"}, 64'(rk_valid), 64'd1);
            if (rk_valid !== 1'b1) break;
            check({t, "_rk"}, 64'(rk), 64'(exp_rk(v, beat)));
            check({t, "_round"}, 64'(rk_round), 64'(beat));
            check({t, "_busy_done"}, {62'd0, busy, done}, 64'd2);
            check({t, "_rk_nocd"}, 64'(rk_b), 64'(exp_rk(v, beat)));
            check({t, "_cd_nocd"}, 64'(cd_out_b), 64'd0);
            if (beat == 0) check({t, "_cd_first"}, 64'(cd_out), 64'(v.first_cd));
            if (beat == 15) check({t, "_cd_last"}, 64'(cd_out), 64'(v.last_cd));
            if (beat == rst_beat) begin
                #2 rst = 1'b0;
                #1 check_idle_outputs({t, "_async_rst"});
                @(posedge clk); #1;
                check_idle_outputs({t, "_held_rst"});
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk); #1;
                check_idle_outputs({t, "_after_rst"});
                return;
            end
            if (beat == start_beat && !injected) begin
                injected = 1;
                start = 1'b1; decrypt = ~v.dec; key_cd = 56'h123456789ABCDE;
            end
            r = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rk_ready = r;
            prk = rk;
            prr = rk_round;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (r) begin
                beat++;
            end else begin
                check({t, "_stall_rk"}, 64'(rk), 64'(prk));
                check({t, "_stall_round"}, 64'(rk_round), 64'(prr));
            end
        end
        t = $sformatf("v%0d", id);
        check({t, "_beats"}, 64'(beat), 64'd16);
        check({t, "_done_state"}, {61'd0, done, busy, rk_valid}, 64'd6);
        if (!v.rnd) check({t, "_cycles"}, 64'(cyc), 64'd16);
        rk_ready = 1'b0;
        @(posedge clk); #1;
        check({t, "_post_done"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; decrypt = 1'b0; key_cd = '0; rk_ready = 1'b0;
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        vecs[0] = '{dec: 1'b0, rnd: 1'b0, key: KEY_CLASSIC, kind: 0, first_cd: CD1_CLASSIC, last_cd: KEY_CLASSIC};
        vecs[1] = '{dec: 1'b1, rnd: 1'b0, key: KEY_CLASSIC, kind: 0, first_cd: KEY_CLASSIC, last_cd: CD1_CLASSIC};
        vecs[2] = '{dec: 1'b0, rnd: 1'b1, key: KEY_CLASSIC, kind: 0, first_cd: CD1_CLASSIC, last_cd: KEY_CLASSIC};
        vecs[3] = '{dec: 1'b1, rnd: 1'b1, key: KEY_CLASSIC, kind: 0, first_cd: KEY_CLASSIC, last_cd: CD1_CLASSIC};
        vecs[4] = '{dec: 1'b0, rnd: 1'b0, key: '1, kind: 1, first_cd: '1, last_cd: '1};
        vecs[5] = '{dec: 1'b1, rnd: 1'b0, key: '1, kind: 1, first_cd: '1, last_cd: '1};
        vecs[6] = '{dec: 1'b0, rnd: 1'b0, key: '0, kind: 2, first_cd: '0, last_cd: '0};
        vecs[7] = '{dec: 1'b1, rnd: 1'b0, key: '0, kind: 2, first_cd: '0, last_cd: '0};

        for (int i = 0; i < 8; i++) begin
            run_sched(vecs[i], i, -1, -1);
        end

        run_sched(vecs[0], 10, 5, -1);
        run_sched(vecs[3], 11, 5, -1);

        run_sched(vecs[0], 20, -1, 7);
        run_sched(vecs[1], 21, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
